// File: rtl/camera_pkg.sv
// rtl/camera_pkg.sv - shared pixel-camera types: ADC arbiter states, defaults, controller states
package camera_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_CONVERT = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_t;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_TIMEOUT = 15;
    localparam int TIMER_W     = 5;

    // Readout sequencer states used by the existing camera controller
    localparam logic [2:0] CTRL_IDLE      = 3'd0;
    localparam logic [2:0] CTRL_RESET_ROW = 3'd1;
    localparam logic [2:0] CTRL_INTEGRATE = 3'd2;
    localparam logic [2:0] CTRL_READ_NRE1 = 3'd3;
    localparam logic [2:0] CTRL_READ_NRE2 = 3'd4;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin picker; last = 1 means channel 2 was served last
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] pick
);

    always_comb begin
        pick = req;
        if (req == 2'b11)
            pick = last ? 2'b01 : 2'b10;
    end

endmodule

// File: rtl/adc_arbiter.sv
// rtl/adc_arbiter.sv - shares the pixel ADC between the NRE_1/NRE_2 readout channels
module adc_arbiter
    import camera_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Req_1,
    input  logic              Req_2,
    output logic              Grant_1,
    output logic              Grant_2,
    output logic              Done_1,
    output logic              Done_2,
    output logic              Timeout,
    output logic [DATA_W-1:0] Data_out,
    output logic              Adc_start,
    input  logic              Adc_valid,
    input  logic [DATA_W-1:0] Adc_data
);

    arb_state_t          state, state_nxt;
    logic [TIMER_W-1:0]  timer, timer_nxt;
    logic                last, last_nxt;
    logic [1:0]          pick;
    logic                start_q, start_nxt;
    logic [1:0]          done_q, done_nxt;
    logic                to_q, to_nxt;
    logic [DATA_W-1:0]   data_q, data_nxt;
    logic                served_req;

    rr_arb2 u_rr_arb2 (
        .req  ({Req_2, Req_1}),
        .last (last),
        .pick (pick)
    );

    // "last" doubles as the owner of the conversion in flight
    assign served_req = last ? Req_2 : Req_1;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= ARB_IDLE;
            timer   <= '0;
            last    <= 1'b1;
            start_q <= 1'b0;
            done_q  <= 2'b00;
            to_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            state   <= state_nxt;
            timer   <= timer_nxt;
            last    <= last_nxt;
            start_q <= start_nxt;
            done_q  <= done_nxt;
            to_q    <= to_nxt;
            data_q  <= data_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        last_nxt  = last;
        start_nxt = 1'b0;
        done_nxt  = 2'b00;
        to_nxt    = 1'b0;
        data_nxt  = data_q;
        case (state)
            ARB_IDLE: begin
                if (pick != 2'b00) begin
                    state_nxt = ARB_CONVERT;
                    start_nxt = 1'b1;
                    timer_nxt = '0;
                    last_nxt  = pick[1];
                end
            end
            ARB_CONVERT: begin
                timer_nxt = timer + 1'b1;
                // Comparing against TIMEOUT-1 lands the abort exactly TIMEOUT edges after the start pulse
                if (Adc_valid) begin
                    data_nxt  = Adc_data;
                    done_nxt  = last ? 2'b10 : 2'b01;
                    state_nxt = ARB_RELEASE;
                end else if (timer == TIMER_W'(TIMEOUT - 1)) begin
                    data_nxt  = '1;
                    done_nxt  = last ? 2'b10 : 2'b01;
                    to_nxt    = 1'b1;
                    state_nxt = ARB_RELEASE;
                end
            end
            ARB_RELEASE: begin
                if (!served_req)
                    state_nxt = ARB_IDLE;
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    assign Grant_1   = (state == ARB_CONVERT) && !last;
    assign Grant_2   = (state == ARB_CONVERT) && last;
    assign Done_1    = done_q[0];
    assign Done_2    = done_q[1];
    assign Timeout   = to_q;
    assign Adc_start = start_q;
    assign Data_out  = data_q;

endmodule

// File: tb/tb_adc_arbiter.sv
// tb/tb_adc_arbiter.sv - directed vector bench for adc_arbiter
module tb_adc_arbiter;

    logic       Clk = 1'b0;
    logic       Reset, Req_1, Req_2, Adc_valid;
    logic [7:0] Adc_data;
    logic       Grant_1, Grant_2, Done_1, Done_2, Timeout, Adc_start;
    logic [7:0] Data_out;

    int n_vec = 0;
    int n_bad = 0;

    // in = {rst, req1, req2, adc_valid}; flags = {g1, g2, done1, done2, timeout, start}
    typedef struct {
        logic [3:0] in;
        logic [7:0] din;
        logic [5:0] flags;
        logic [7:0] dout;
    } vec_t;

    vec_t vecs [25];

    adc_arbiter #(.DATA_W(8), .TIMEOUT(15)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Req_1     (Req_1),
        .Req_2     (Req_2),
        .Grant_1   (Grant_1),
        .Grant_2   (Grant_2),
        .Done_1    (Done_1),
        .Done_2    (Done_2),
        .Timeout   (Timeout),
        .Data_out  (Data_out),
        .Adc_start (Adc_start),
        .Adc_valid (Adc_valid),
        .Adc_data  (Adc_data)
    );

    always #5 Clk = ~Clk;

    task automatic step(input logic rst, input logic r1, input logic r2,
                        input logic v, input logic [7:0] d);
        Reset     = rst;
        Req_1     = r1;
        Req_2     = r2;
        Adc_valid = v;
        Adc_data  = d;
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [5:0] ef, input logic [7:0] ed);
        logic [5:0] af;
        af = {Grant_1, Grant_2, Done_1, Done_2, Timeout, Adc_start};
        n_vec++;
        if (af !== ef || Data_out !== ed) begin
            n_bad++;
            $display("FAIL %s: got flags=%b data=%h, expected flags=%b data=%h",
                     name, af, Data_out, ef, ed);
        end
    endtask

    initial begin
        vecs[0]  = '{4'b1000, 8'h00, 6'b000000, 8'h00};
        vecs[1]  = '{4'b0100, 8'h00, 6'b100001, 8'h00};
        vecs[2]  = '{4'b0100, 8'h00, 6'b100000, 8'h00};
        vecs[3]  = '{4'b0100, 8'h00, 6'b100000, 8'h00};
        vecs[4]  = '{4'b0101, 8'h5A, 6'b001000, 8'h5A};
        vecs[5]  = '{4'b0101, 8'h77, 6'b000000, 8'h5A};
        vecs[6]  = '{4'b0100, 8'h00, 6'b000000, 8'h5A};
        vecs[7]  = '{4'b0001, 8'h11, 6'b000000, 8'h5A};
        vecs[8]  = '{4'b0001, 8'h22, 6'b000000, 8'h5A};
        vecs[9]  = '{4'b1110, 8'h00, 6'b000000, 8'h00};
        vecs[10] = '{4'b0110, 8'h00, 6'b100001, 8'h00};
        vecs[11] = '{4'b0111, 8'hAA, 6'b001000, 8'hAA};
        vecs[12] = '{4'b0010, 8'h00, 6'b000000, 8'hAA};
        vecs[13] = '{4'b0010, 8'h00, 6'b010001, 8'hAA};
        vecs[14] = '{4'b0111, 8'hBB, 6'b000100, 8'hBB};
        vecs[15] = '{4'b0100, 8'h00, 6'b000000, 8'hBB};
        vecs[16] = '{4'b0110, 8'h00, 6'b100001, 8'hBB};
        vecs[17] = '{4'b0111, 8'hCC, 6'b001000, 8'hCC};
        vecs[18] = '{4'b0010, 8'h00, 6'b000000, 8'hCC};
        vecs[19] = '{4'b0110, 8'h00, 6'b010001, 8'hCC};
        vecs[20] = '{4'b0111, 8'hDD, 6'b000100, 8'hDD};
        vecs[21] = '{4'b0100, 8'h00, 6'b000000, 8'hDD};
        vecs[22] = '{4'b0100, 8'h00, 6'b100001, 8'hDD};
        vecs[23] = '{4'b0001, 8'hEE, 6'b001000, 8'hEE};
        vecs[24] = '{4'b0000, 8'h00, 6'b000000, 8'hEE};

        Reset = 1'b1; Req_1 = 1'b0; Req_2 = 1'b0; Adc_valid = 1'b0; Adc_data = 8'h00;

        for (int i = 0; i < 25; i++) begin
            step(vecs[i].in[3], vecs[i].in[2], vecs[i].in[1], vecs[i].in[0], vecs[i].din);
            chk($sformatf("vec%0d", i), vecs[i].flags, vecs[i].dout);
        end

        // Channel 2 conversion with no ADC response
        step(1, 0, 0, 0, 8'h00);         chk("to_reset", 6'b000000, 8'h00);
        step(0, 0, 1, 0, 8'h00);         chk("to_grant", 6'b010001, 8'h00);
        for (int i = 1; i < 15; i++) begin
            step(0, 0, 1, 0, 8'h00);
            chk($sformatf("to_wait%0d", i), 6'b010000, 8'h00);
        end
        step(0, 0, 1, 0, 8'h00);         chk("to_abort", 6'b000110, 8'hFF);
        step(0, 0, 0, 0, 8'h00);         chk("to_release", 6'b000000, 8'hFF);

        // Valid arriving on the very cycle the timer would expire
        step(0, 1, 0, 0, 8'h00);         chk("race_grant", 6'b100001, 8'hFF);
        for (int i = 1; i < 15; i++) begin
            step(0, 1, 0, 0, 8'h00);
            chk($sformatf("race_wait%0d", i), 6'b100000, 8'hFF);
        end
        step(0, 1, 0, 1, 8'h33);         chk("race_valid", 6'b001000, 8'h33);
        step(0, 0, 0, 0, 8'h00);         chk("race_release", 6'b000000, 8'h33);

        // Reset in the middle of a conversion
        step(0, 0, 1, 0, 8'h00);         chk("mid_grant", 6'b010001, 8'h33);
        step(0, 0, 1, 0, 8'h00);         chk("mid_conv", 6'b010000, 8'h33);
        step(1, 0, 1, 1, 8'h44);         chk("mid_reset", 6'b000000, 8'h00);
        step(0, 0, 1, 0, 8'h00);         chk("post_grant2", 6'b010001, 8'h00);
        step(0, 0, 1, 1, 8'h66);         chk("post_done2", 6'b000100, 8'h66);
        step(0, 0, 0, 0, 8'h00);         chk("post_idle", 6'b000000, 8'h66);
        step(0, 1, 1, 0, 8'h00);         chk("post_tie_ch1", 6'b100001, 8'h66);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/adc_arbiter.md
# adc_arbiter

Shares the single pixel-array ADC between the two readout channels (NRE_1 / NRE_2 paths) of the pixel camera. Each channel requests a conversion with a four-phase req/done handshake; the arbiter grants round-robin, issues the ADC start pulse, captures the sample and returns it to the granted channel. It has a conversion timeout so a missing ADC response cannot hang the readout sequence.

## Interface
Parameters:
- DATA_W, 8, ADC sample width.
- TIMEOUT, 15, max cycles in CONVERT before abort (≥2, fits 5-bit counter).

Ports:
- Clk  input  1  system clock; all logic on rising edge.
- Reset  input  1  synchronous, active-high.
- Req_1, Req_2  input  1  conversion request per channel; held until Done seen, then dropped.
- Grant_1, Grant_2  output  1  channel owns ADC; one-hot or zero.
- Done_1, Done_2  output  1  one-cycle pulse: Data_out valid for that channel.
- Timeout  output  1  qualifies Done_x: conversion aborted, Data_out = all ones.
- Data_out  output  DATA_W  captured sample, held until next capture.
- Adc_start  output  1  one-cycle convert pulse to ADC.
- Adc_valid  input  1  one-cycle pulse from ADC: Adc_data valid.
- Adc_data  input  DATA_W  ADC result.

## Operation
- Reset (Reset = 1 at an edge): all outputs 0, Data_out = 0, state IDLE, timer = 0, round-robin pointer = "last served 2" (channel 1 wins first tie). Reset mid-conversion aborts with no Done.
- States: IDLE, CONVERT, RELEASE.
- IDLE: if exactly one Req high, select it; if both high, select the channel not last served; go CONVERT, assert Grant_x, pulse Adc_start, clear timer, update pointer. Adc_valid ignored in IDLE.
- CONVERT: Adc_start low; timer increments each cycle.
  - Adc_valid = 1: Data_out <= Adc_data, Done_x pulse, Timeout = 0, Grant_x low, go RELEASE.
  - Else timer == TIMEOUT: Data_out <= all ones, Done_x and Timeout pulse, Grant_x low, go RELEASE.
  - Adc_valid and timeout in same cycle: valid wins, Timeout = 0.
  - Granted Req dropping early is ignored; conversion completes normally.
- RELEASE: Done/Timeout low; stay until served channel's Req = 0, then IDLE. Other channel's Req waits.
- Grant_x never both high; Done_x only for granted channel.

## Timing
- Req_x sampled high in IDLE at edge k → Grant_x and Adc_start high after edge k (one cycle for Adc_start).
- Adc_valid sampled at edge m → Done_x, Data_out updated after m; Grant_x low from the same edge.
- Timeout: Adc_start after edge k, no valid → Done_x + Timeout after edge k+TIMEOUT.
- Minimum request-to-request turnaround: Req drop seen in RELEASE → IDLE next cycle → next grant one cycle later (≥3 cycles between Adc_start pulses).
- Simultaneous Req_1/Req_2 always alternate when both held high.

## Structure
- Shared package camera_pkg: arbiter state encoding (IDLE/CONVERT/RELEASE), default DATA_W, TIMEOUT, and the existing controller state constants.
- One sub-module: rr_arb2 — 2-way round-robin picker (req[1:0], last pointer in; one-hot pick out), purely combinational plus the pointer register held in adc_arbiter.
- Timer and FSM inline in adc_arbiter.

## Test plan
- Reset, then Req_1 = 1, ADC returns Adc_valid with 0x5A three cycles after Adc_start → Grant_1 for 3 cycles, Done_1 pulse, Data_out = 0x5A, Timeout = 0.
- Req_1 and Req_2 high together from reset, each held until Done → order 1, 2, 1, 2; Grant never both high.
- Req_2 only, ADC never responds, TIMEOUT = 15 → Done_2 and Timeout 15 cycles after Adc_start, Data_out = 0xFF.
- Adc_valid with 0x33 on exactly the timeout cycle → Done_x, Timeout = 0, Data_out = 0x33.
- Reset asserted while in CONVERT → next cycle all outputs 0, no Done; following Req_2 alone is granted normally; Req_1+Req_2 together → channel 1 first.
- Adc_valid pulses while IDLE and Req_1 held after Done (RELEASE) → no Done, no new grant until Req_1 drops.
